trig_pid_window: RTL and testbench

Parametrised multi-channel trigger-time classifier for the trigger TDC path. After a reference start pulse it time-stamps the first rising edge on each channel within a gate. It then counts the stamped channels falling inside three programmable windows and pulses electron/muon/pion decisions against per-class thresholds. It sits after the input register stage, on the shared local register bus, and generalises the fixed 48-channel PID path with runtime-programmable windows, thresholds and per-channel time readback.

---
 rtl/trig_pid_window_if.sv | 13 +
 rtl/trig_pid_window.sv | 186 ++++++++++++++++++
 tb/tb_trig_pid_window.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trig_pid_window_if.sv
// Local register bus shared by the trigger-path blocks.
// Read data is wired-OR, so a slave drives zero whenever it is not addressed.
interface trig_pid_window_if;
  logic [31:0] DataIn;
  logic [7:0]  Address;
  logic        Read;
  logic        Write;
  logic [31:0] DataOut;
  logic        ack;

  modport master (output DataIn, Address, Read, Write, input DataOut, ack);
  modport slave  (input DataIn, Address, Read, Write, output DataOut, ack);
endinterface

// File: rtl/trig_pid_window.sv
// Multi-channel trigger-time classifier: stamps the first hit edge per channel inside a
// gate after start, then pulses electron/muon/pion when enough stamps land in each window.
module trig_pid_window #(
  parameter int         NCH       = 48,
  parameter int         TW        = 8,
  parameter logic [7:0] BASE_ADDR = 8'hD0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NCH-1:0]       hits,
  trig_pid_window_if.slave     bus,
  output logic                 electron,
  output logic                 muon,
  output logic                 pion,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, MEASURE = 2'd1, DECIDE = 2'd2} state_t;

  localparam logic [TW-1:0] WIN_RST = TW'(32'd16);
  localparam logic [23:0]   ELEC_RST = 24'h01_0300;
  localparam logic [23:0]   MUON_RST = 24'h01_0904;
  localparam logic [23:0]   PION_RST = 24'h02_0F0A;

  state_t          state_r, state_nxt_s;
  logic [TW-1:0]   win_r, win_snap_r, cnt_r;
  logic            en_r;
  logic [23:0]     cls_r [3];
  logic [23:0]     cls_snap_r [3];
  logic [7:0]      chsel_r;
  logic [TW-1:0]   stamp_r [NCH];
  logic [NCH-1:0]  valid_r, hits_q_r, edge_s;
  logic [7:0]      evt_cnt_r;
  logic [2:0]      last_r, dec_r, fire_s;
  logic [7:0]      n_s [3];
  logic            ack_r, hit_s, wr_s, arm_s, sel_valid_s, unused_s;
  logic [7:0]      off_s;
  logic [TW-1:0]   sel_stamp_s;
  logic [31:0]     rdata_s;

  // Inclusive window test on a zero-extended stamp; lo > hi can never match.
  function automatic logic in_window(input logic v, input logic [TW-1:0] st, input logic [23:0] cls);
    logic [15:0] st16;
    st16 = 16'(st);
    return v && (st16 >= {8'd0, cls[7:0]}) && (st16 <= {8'd0, cls[15:8]});
  endfunction

  assign off_s    = bus.Address - BASE_ADDR;
  assign hit_s    = (off_s < 8'd6);
  assign wr_s     = bus.Write & hit_s;
  assign arm_s    = (state_r == IDLE) & start & en_r;
  assign edge_s   = hits & ~hits_q_r;
  assign unused_s = ^bus.DataIn;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (arm_s) state_nxt_s = MEASURE; else state_nxt_s = IDLE;
      MEASURE: if (cnt_r == win_snap_r) state_nxt_s = DECIDE; else state_nxt_s = MEASURE;
      DECIDE:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Programmable register bank; writes are accepted in any state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_r    <= WIN_RST;
      en_r     <= 1'b1;
      cls_r[0] <= ELEC_RST;
      cls_r[1] <= MUON_RST;
      cls_r[2] <= PION_RST;
      chsel_r  <= 8'd0;
    end else if (wr_s) begin
      case (off_s)
        8'd0: begin
          win_r <= bus.DataIn[TW-1:0];
          en_r  <= bus.DataIn[16];
        end
        8'd1: cls_r[0] <= bus.DataIn[23:0];
        8'd2: cls_r[1] <= bus.DataIn[23:0];
        8'd3: cls_r[2] <= bus.DataIn[23:0];
        8'd5: chsel_r  <= bus.DataIn[7:0];
        default: ;
      endcase
    end
  end

  // Gate counter, edge history, first-edge stamps and the per-event configuration snapshot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hits_q_r   <= {NCH{1'b0}};
      cnt_r      <= {TW{1'b0}};
      valid_r    <= {NCH{1'b0}};
      win_snap_r <= {TW{1'b0}};
      for (int k = 0; k < 3; k++) cls_snap_r[k] <= 24'd0;
      for (int i = 0; i < NCH; i++) stamp_r[i] <= {TW{1'b0}};
    end else begin
      hits_q_r <= hits;
      if (arm_s) begin
        cnt_r      <= {TW{1'b0}};
        valid_r    <= {NCH{1'b0}};
        win_snap_r <= win_r;
        cls_snap_r <= cls_r;
        for (int i = 0; i < NCH; i++) stamp_r[i] <= {TW{1'b0}};
      end else if (state_r == MEASURE) begin
        cnt_r <= cnt_r + TW'(1'b1);
        for (int i = 0; i < NCH; i++) begin
          if (edge_s[i] && !valid_r[i]) begin
            stamp_r[i] <= cnt_r;
            valid_r[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Per-class window counts and threshold decisions
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      n_s[k] = 8'd0;
      for (int i = 0; i < NCH; i++)
        n_s[k] = n_s[k] + {7'd0, in_window(valid_r[i], stamp_r[i], cls_snap_r[k])};
      fire_s[k] = (n_s[k] >= cls_snap_r[k][23:16]) && (cls_snap_r[k][23:16] != 8'd0);
    end
  end

  // Registered decision pulses, status history and event counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_r     <= 3'd0;
      last_r    <= 3'd0;
      evt_cnt_r <= 8'd0;
      ack_r     <= 1'b0;
    end else begin
      ack_r <= (bus.Read | bus.Write) & hit_s;
      if (state_r == DECIDE) begin
        dec_r     <= fire_s;
        last_r    <= fire_s;
        evt_cnt_r <= evt_cnt_r + 8'd1;
      end else begin
        dec_r <= 3'd0;
      end
    end
  end

  // Channel-select readback mux; out-of-range selects match nothing and read zero
  always_comb begin
    sel_valid_s = 1'b0;
    sel_stamp_s = {TW{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      sel_valid_s = sel_valid_s | (valid_r[i] & (chsel_r == 8'(i)));
      sel_stamp_s = sel_stamp_s | (stamp_r[i] & {TW{chsel_r == 8'(i)}});
    end
  end

  // Register read data
  always_comb begin
    rdata_s = 32'd0;
    case (off_s)
      8'd0:    rdata_s = {15'd0, en_r, 16'(win_r)};
      8'd1:    rdata_s = {8'd0, cls_r[0]};
      8'd2:    rdata_s = {8'd0, cls_r[1]};
      8'd3:    rdata_s = {8'd0, cls_r[2]};
      8'd4:    rdata_s = {16'd0, evt_cnt_r, 3'd0, last_r, state_r};
      8'd5:    rdata_s = {sel_valid_s, 7'd0, chsel_r, 16'(sel_stamp_s)};
      default: rdata_s = 32'd0;
    endcase
  end

  assign bus.DataOut = (rst && bus.Read && hit_s) ? rdata_s : 32'd0;
  assign bus.ack     = ack_r;
  assign electron    = dec_r[0];
  assign muon        = dec_r[1];
  assign pion        = dec_r[2];
  assign busy        = (state_r == MEASURE) || (state_r == DECIDE);

endmodule

// File: tb/tb_trig_pid_window.sv
// Directed bench for trig_pid_window: register map, event timing, windows, thresholds,
// ignored starts, snapshot behaviour, counter wrap and asynchronous reset.
module tb_trig_pid_window;
  localparam int         NCH  = 48;
  localparam int         TW   = 8;
  localparam logic [7:0] BASE = 8'hD0;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [NCH-1:0] hits;
  logic           electron, muon, pion, busy;
  logic           seen;
  int             n_tests = 0;
  int             n_fail  = 0;

  trig_pid_window_if bus();

  trig_pid_window #(.NCH(NCH), .TW(TW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .hits(hits), .bus(bus.slave),
    .electron(electron), .muon(muon), .pion(pion), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [7:0] off, input logic [31:0] d);
    bus.Address = BASE + off;
    bus.DataIn  = d;
    bus.Write   = 1'b1;
    cyc(1);
    bus.Write = 1'b0;
    chk("wr_ack", {31'd0, bus.ack}, 32'd1);
  endtask

  task automatic bus_rd(input string tag, input logic [7:0] off, input logic [31:0] exp);
    bus.Address = BASE + off;
    bus.Read    = 1'b1;
    #1;
    chk(tag, bus.DataOut, exp);
    cyc(1);
    bus.Read = 1'b0;
    chk("rd_ack", {31'd0, bus.ack}, 32'd1);
  endtask

  // One event: pre = hits during the start cycle; (c1,m1),(c2,m2) = hit masks at counter values;
  // rs_at = counter at which start is re-pulsed; wr_at = counter of a mid-event bus write.
  task automatic run_event(input string tag, input int win, input logic [NCH-1:0] pre,
                           input int c1, input logic [NCH-1:0] m1,
                           input int c2, input logic [NCH-1:0] m2,
                           input int rs_at, input int wr_at, input logic [7:0] wr_off,
                           input logic [31:0] wr_data, input logic [2:0] exp_dec);
    start = 1'b1;
    hits  = pre;
    chk({tag, "_busy_t0"}, {31'd0, busy}, 32'd0);
    cyc(1);
    start = 1'b0;
    for (int c = 0; c <= win; c++) begin
      hits  = ((c == c1) ? m1 : {NCH{1'b0}}) | ((c == c2) ? m2 : {NCH{1'b0}});
      start = (c == rs_at);
      if (c == wr_at) begin
        bus.Address = BASE + wr_off;
        bus.DataIn  = wr_data;
        bus.Write   = 1'b1;
      end else begin
        bus.Write = 1'b0;
      end
      if (c == 0) chk({tag, "_busy_meas"}, {31'd0, busy}, 32'd1);
      cyc(1);
    end
    hits      = {NCH{1'b0}};
    start     = 1'b0;
    bus.Write = 1'b0;
    chk({tag, "_busy_decide"}, {31'd0, busy}, 32'd1);
    chk({tag, "_dec_early"}, {29'd0, pion, muon, electron}, 32'd0);
    cyc(1);
    chk({tag, "_dec"}, {29'd0, pion, muon, electron}, {29'd0, exp_dec});
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    cyc(1);
    chk({tag, "_dec_late"}, {29'd0, pion, muon, electron}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hits = {NCH{1'b0}};
    bus.Address = 8'd0; bus.DataIn = 32'd0; bus.Read = 1'b0; bus.Write = 1'b0;
    #1 rst = 1'b0;
    cyc(2);
    bus.Address = BASE;
    bus.Read    = 1'b1;
    #1;
    chk("rst_dout", bus.DataOut, 32'd0);
    chk("rst_ack", {31'd0, bus.ack}, 32'd0);
    chk("rst_dec", {29'd0, pion, muon, electron}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    bus.Read = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(1);

    bus_rd("rst_ctrl", 8'd0, 32'h0001_0010);
    bus_rd("rst_elec", 8'd1, 32'h0001_0300);
    bus_rd("rst_muon", 8'd2, 32'h0001_0904);
    bus_rd("rst_pion", 8'd3, 32'h0002_0F0A);
    bus_rd("rst_status", 8'd4, 32'h0000_0000);
    bus_rd("rst_chsel", 8'd5, 32'h0000_0000);
    chk("idle_dout", bus.DataOut, 32'd0);

    // Unmapped address: no data, no ack
    bus.Address = BASE + 8'd6;
    bus.Read    = 1'b1;
    #1;
    chk("unmapped_dout", bus.DataOut, 32'd0);
    cyc(1);
    bus.Read = 1'b0;
    chk("unmapped_ack", {31'd0, bus.ack}, 32'd0);

    // Electron with defaults: ch0/ch1 at counter 2
    run_event("elec", 16, 48'h0, 2, 48'h3, -1, 48'h0, -1, -1, 8'd0, 32'd0, 3'b001);
    bus_wr(8'd5, 32'd1);
    bus_rd("elec_ch1", 8'd5, 32'h8001_0002);
    bus_rd("elec_status", 8'd4, 32'h0000_0104);
    bus_wr(8'd5, 32'd48);
    bus_rd("chsel_oob", 8'd5, 32'h0030_0000);

    // Pion threshold 2
    run_event("pion1", 16, 48'h0, 12, 48'h20, -1, 48'h0, -1, -1, 8'd0, 32'd0, 3'b000);
    run_event("pion2", 16, 48'h0, 12, 48'h8000_0000_0020, 14, 48'h20, -1, -1, 8'd0, 32'd0, 3'b100);
    bus_wr(8'd5, 32'd5);
    bus_rd("pion_ch5", 8'd5, 32'h8005_000C);
    bus_wr(8'd5, 32'd47);
    bus_rd("pion_ch47", 8'd5, 32'h802F_000C);

    // WIN=0: one MEASURE cycle, decisions at T0+3
    bus_wr(8'd0, 32'h0001_0000);
    run_event("win0", 0, 48'h0, 0, 48'h1, -1, 48'h0, -1, -1, 8'd0, 32'd0, 3'b001);
    bus_wr(8'd0, 32'h0001_0010);

    // Stamp equal to hi is counted; two classes fire together
    run_event("hi_edge", 16, 48'h0, 3, 48'h1, 9, 48'h2, -1, -1, 8'd0, 32'd0, 3'b011);

    // lo > hi never fires
    bus_wr(8'd1, 32'h0001_0005);
    run_event("lo_gt_hi", 16, 48'h0, 2, 48'h1, 5, 48'h2, -1, -1, 8'd0, 32'd0, 3'b010);

    // thr = 0 never fires
    bus_wr(8'd1, 32'h0000_0300);
    run_event("thr0", 16, 48'h0, 2, 48'h1, -1, 48'h0, -1, -1, 8'd0, 32'd0, 3'b000);
    bus_wr(8'd1, 32'h0001_0300);

    // Edge in the start cycle is not stamped
    run_event("t0_hit", 16, 48'h1, -1, 48'h0, -1, 48'h0, -1, -1, 8'd0, 32'd0, 3'b000);
    bus_wr(8'd5, 32'd0);
    bus_rd("t0_ch0", 8'd5, 32'h0000_0000);

    // start during MEASURE is ignored
    run_event("restart", 16, 48'h0, 1, 48'h1, -1, 48'h0, 5, -1, 8'd0, 32'd0, 3'b001);

    // MUON rewritten mid-event: old window for this event, new one for the next
    run_event("muon_old", 16, 48'h0, 5, 48'h1, -1, 48'h0, -1, 3, 8'd2, 32'h0001_1F10, 3'b010);
    bus_rd("muon_new_reg", 8'd2, 32'h0001_1F10);
    run_event("muon_new", 16, 48'h0, 5, 48'h1, -1, 48'h0, -1, -1, 8'd0, 32'd0, 3'b000);
    bus_wr(8'd2, 32'h0001_0904);
    bus_rd("status_11", 8'd4, 32'h0000_0B00);

    // enable = 0 blocks start
    bus_wr(8'd0, 32'h0000_0010);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("dis_busy", {31'd0, busy}, 32'd0);
    cyc(3);
    chk("dis_busy_late", {31'd0, busy}, 32'd0);
    bus_rd("dis_status", 8'd4, 32'h0000_0B00);

    // Event counter wrap using back-to-back WIN=0 events
    bus_wr(8'd0, 32'h0001_0000);
    repeat (244) begin
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(2);
    end
    bus_rd("cnt_255", 8'd4, 32'h0000_FF00);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);
    bus_rd("cnt_wrap", 8'd4, 32'h0000_0000);
    bus_wr(8'd0, 32'h0001_0010);

    // Asynchronous reset mid-MEASURE
    bus_wr(8'd3, 32'h0003_0F0A);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    hits = 48'h1;
    cyc(1);
    hits = 48'h0;
    cyc(2);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_dec", {29'd0, pion, muon, electron}, 32'd0);
    cyc(1);
    rst  = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      cyc(1);
      seen = seen | electron | muon | pion | busy;
    end
    chk("arst_quiet", {31'd0, seen}, 32'd0);
    bus_rd("arst_pion", 8'd3, 32'h0002_0F0A);
    bus_rd("arst_chsel", 8'd5, 32'h0000_0000);
    bus_rd("arst_status", 8'd4, 32'h0000_0000);
    run_event("post_rst", 16, 48'h0, 2, 48'h3, -1, 48'h0, -1, -1, 8'd0, 32'd0, 3'b001);
    bus_rd("post_status", 8'd4, 32'h0000_0104);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
